reducer_seq_ctrl: RTL and testbench

- Sequences the row reducer over a pass of N output tiles.
- Per tile it:
  - fetches one ipsum vector from the psum buffer;
  - waits for a product vector from the PE array;
  - captures the reducer result;
  - drains the opsum words serially to the opsum buffer through a valid/ready handshake.
- Drives the reducer's mode select.
- Compacts DW/CONV results: only 10 lanes (0,3,...,27) are written back, not 32.

---
 rtl/reducer_seq_ctrl_if.sv | 33 +++
 rtl/reducer_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_reducer_seq_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reducer_seq_ctrl_if.sv
// Bus bundle between the reducer sequencer and its psum buffers, PE array and row reducer.
// master = sequencer side, slave = buffers/array/reducer side.
interface reducer_seq_ctrl_if #(
  parameter int unsigned ROW_NUM = 32,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16
);
  logic                        ipsum_req;
  logic [ADDR_W-1:0]           ipsum_addr;
  logic                        ipsum_valid;
  logic [ROW_NUM*DATA_W-1:0]   ipsum_vec;
  logic                        array_valid;
  logic                        array_ready;
  logic [ROW_NUM*DATA_W-1:0]   ipsum2reducer;
  logic                        DW_PW_sel;
  logic [ROW_NUM*DATA_W-1:0]   reducer2opsum;
  logic                        opsum_valid;
  logic                        opsum_ready;
  logic [DATA_W-1:0]           opsum_data;
  logic [ADDR_W-1:0]           opsum_addr;

  modport master (
    output ipsum_req, ipsum_addr, array_ready, ipsum2reducer, DW_PW_sel,
    output opsum_valid, opsum_data, opsum_addr,
    input  ipsum_valid, ipsum_vec, array_valid, reducer2opsum, opsum_ready
  );

  modport slave (
    input  ipsum_req, ipsum_addr, array_ready, ipsum2reducer, DW_PW_sel,
    input  opsum_valid, opsum_data, opsum_addr,
    output ipsum_valid, ipsum_vec, array_valid, reducer2opsum, opsum_ready
  );
endinterface

// File: rtl/reducer_seq_ctrl.sv
// Row-reducer sequencer: per tile fetch ipsum, accept PE product, capture sum, drain opsum words.
// Optional REDUCER_SEQ_RELU_EN clamps negative emitted opsum words to zero.
module reducer_seq_ctrl #(
  parameter int unsigned ROW_NUM = 32,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DW_GRP  = 10,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [15:0]        num_tiles,
  input  logic [ADDR_W-1:0]  base_addr,
  output logic               busy,
  output logic               done,
  reducer_seq_ctrl_if.master bus
);
  localparam int unsigned IDX_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int unsigned VEC_W = ROW_NUM * DATA_W;

  typedef enum logic [2:0] {StIdle, StFetch, StWaitArr, StDrain, StFin} state_e;

  state_e                         state_q, state_d;
  logic                           mode_q, mode_d;
  logic [15:0]                    num_tiles_q, num_tiles_d;
  logic [15:0]                    tile_q, tile_d;
  logic [ADDR_W-1:0]              tile_addr_q, tile_addr_d;
  logic [IDX_W-1:0]               word_q, word_d;
  logic [VEC_W-1:0]               ipsum_q, ipsum_d;
  logic [ROW_NUM-1:0][DATA_W-1:0] res_q, res_d;

  logic [ADDR_W-1:0] words_per_tile;
  logic              last_word;
  logic              last_tile;
  logic [IDX_W-1:0]  lane;
  logic [DATA_W-1:0] lane_data;

  assign words_per_tile = mode_q ? ADDR_W'(ROW_NUM) : ADDR_W'(DW_GRP);
  assign last_word      = mode_q ? (word_q == IDX_W'(ROW_NUM - 1))
                                 : (word_q == IDX_W'(DW_GRP - 1));
  assign last_tile      = (tile_q == num_tiles_q - 16'd1);
  // DW sums live in the first lane of each 3-row group
  assign lane           = mode_q ? word_q : IDX_W'(32'(word_q) * 3);
  assign lane_data      = res_q[lane];

  assign bus.ipsum2reducer = ipsum_q;
  assign bus.DW_PW_sel     = mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      num_tiles_q <= '0;
      tile_q      <= '0;
      tile_addr_q <= '0;
      word_q      <= '0;
      ipsum_q     <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      num_tiles_q <= num_tiles_d;
      tile_q      <= tile_d;
      tile_addr_q <= tile_addr_d;
      word_q      <= word_d;
      ipsum_q     <= ipsum_d;
      res_q       <= res_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    num_tiles_d     = num_tiles_q;
    tile_d          = tile_q;
    tile_addr_d     = tile_addr_q;
    word_d          = word_q;
    ipsum_d         = ipsum_q;
    res_d           = res_q;
    busy            = 1'b0;
    done            = 1'b0;
    bus.ipsum_req   = 1'b0;
    bus.ipsum_addr  = '0;
    bus.array_ready = 1'b0;
    bus.opsum_valid = 1'b0;
    bus.opsum_data  = '0;
    bus.opsum_addr  = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d      = mode;
          num_tiles_d = num_tiles;
          tile_addr_d = base_addr;
          tile_d      = '0;
          state_d     = (num_tiles == 16'd0) ? StFin : StFetch;
        end
      end
      StFetch: begin
        busy           = 1'b1;
        bus.ipsum_req  = 1'b1;
        bus.ipsum_addr = tile_addr_q;
        if (bus.ipsum_valid) begin
          ipsum_d = bus.ipsum_vec;
          state_d = StWaitArr;
        end
      end
      StWaitArr: begin
        busy = 1'b1;
        if (bus.array_valid) begin
          bus.array_ready = 1'b1;
          res_d           = bus.reducer2opsum;
          word_d          = '0;
          state_d         = StDrain;
        end
      end
      StDrain: begin
        busy            = 1'b1;
        bus.opsum_valid = 1'b1;
        bus.opsum_addr  = tile_addr_q + ADDR_W'(word_q);
`ifdef REDUCER_SEQ_RELU_EN
        bus.opsum_data  = lane_data[DATA_W-1] ? '0 : lane_data;
`else
        bus.opsum_data  = lane_data;
`endif
        if (bus.opsum_ready) begin
          if (last_word) begin
            word_d = '0;
            if (last_tile) begin
              state_d = StFin;
            end else begin
              tile_d      = tile_q + 16'd1;
              tile_addr_d = tile_addr_q + words_per_tile;
              state_d     = StFetch;
            end
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end
endmodule

// File: tb/tb_reducer_seq_ctrl.sv
// Directed bench for reducer_seq_ctrl: PW/DW passes, backpressure, empty pass, ignored start,
// mid-pass reset and the optional ReLU output stage.
module tb_reducer_seq_ctrl;
  localparam int unsigned ROW_NUM = 32;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DW_GRP  = 10;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned VEC_W   = ROW_NUM * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mode;
  logic [15:0]       num_tiles;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;

  int n_tests = 0;
  int n_fail  = 0;

  reducer_seq_ctrl_if #(.ROW_NUM(ROW_NUM), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) sif ();

  reducer_seq_ctrl #(
    .ROW_NUM (ROW_NUM),
    .DATA_W  (DATA_W),
    .DW_GRP  (DW_GRP),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .num_tiles (num_tiles),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .bus       (sif)
  );

  always #5 clk = ~clk;

  // Monitor: sampled mid-cycle, records handshakes and event counts
  int                cyc = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  logic [ADDR_W-1:0] fetch_addr[$];
  int done_cnt = 0, done_cyc = 0, arr_cnt = 0, req_cnt = 0, valid_cnt = 0;
  int busy_cnt = 0, pw_cnt = 0, stall_cnt = 0, stall_viol = 0;
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sif.opsum_valid && sif.opsum_ready) begin
      wr_addr.push_back(sif.opsum_addr);
      wr_data.push_back(sif.opsum_data);
    end
    if (sif.ipsum_req && sif.ipsum_valid) fetch_addr.push_back(sif.ipsum_addr);
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (sif.array_ready) arr_cnt <= arr_cnt + 1;
    if (sif.ipsum_req) req_cnt <= req_cnt + 1;
    if (sif.opsum_valid) valid_cnt <= valid_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (busy && sif.DW_PW_sel) pw_cnt <= pw_cnt + 1;
    if (prev_stall && (!sif.opsum_valid || sif.opsum_addr !== prev_addr ||
                       sif.opsum_data !== prev_data)) stall_viol <= stall_viol + 1;
    if (sif.opsum_valid && !sif.opsum_ready) stall_cnt <= stall_cnt + 1;
    prev_stall <= sif.opsum_valid && !sif.opsum_ready;
    prev_addr  <= sif.opsum_addr;
    prev_data  <= sif.opsum_data;
  end

  function automatic logic [VEC_W-1:0] ramp(input logic [DATA_W-1:0] off);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int k = 0; k < ROW_NUM; k++) v[k*DATA_W +: DATA_W] = off + DATA_W'(k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic m, input logic [15:0] n, input logic [ADDR_W-1:0] b,
                          output int sc);
    tick();
    start = 1'b1; mode = m; num_tiles = n; base_addr = b;
    tick();
    sc    = cyc;
    start = 1'b0; mode = ~m; num_tiles = 16'hFFFF; base_addr = '1;
  endtask

  task automatic wait_done(input int d0, input int bound, output bit to);
    to = 1'b1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done_cnt > d0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b1; num_tiles = 16'd3; base_addr = 16'h1234;
    sif.ipsum_valid = 1'b1; sif.ipsum_vec = ramp(16'hA000); sif.array_valid = 1'b1;
    sif.reducer2opsum = ramp(16'h0001); sif.opsum_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_tests++; if (sif.ipsum_req !== 1'b0 || sif.ipsum_addr !== '0) begin
      n_fail++; $display("FAIL reset_ipsum got req=%0b addr=%h want 0/0", sif.ipsum_req, sif.ipsum_addr);
    end
    n_tests++; if (sif.array_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_array_ready got %0b want 0", sif.array_ready);
    end
    n_tests++; if (sif.ipsum2reducer !== '0) begin
      n_fail++; $display("FAIL reset_ipsum2reducer got nonzero want 0");
    end
    n_tests++; if (sif.DW_PW_sel !== 1'b0) begin
      n_fail++; $display("FAIL reset_sel got %0b want 0", sif.DW_PW_sel);
    end
    n_tests++; if (sif.opsum_valid !== 1'b0 || sif.opsum_data !== '0 || sif.opsum_addr !== '0) begin
      n_fail++; $display("FAIL reset_opsum got v=%0b d=%h a=%h want 0/0/0",
                         sif.opsum_valid, sif.opsum_data, sif.opsum_addr);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_pw_pass();
    int sc, w0, f0, d0, b0, a0, nw;
    bit to;
    sif.ipsum_vec = ramp(16'hA000); sif.reducer2opsum = ramp(16'h0001);
    w0 = wr_addr.size(); f0 = fetch_addr.size(); d0 = done_cnt; b0 = busy_cnt; a0 = arr_cnt;
    do_start(1'b1, 16'd2, 16'h0100, sc);
    wait_done(d0, 300, to);
    repeat (3) tick();
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL pw_timeout got timeout want done"); end
    nw = wr_addr.size() - w0;
    n_tests++; if (nw != 64) begin n_fail++; $display("FAIL pw_count got %0d want 64", nw); end
    for (int j = 0; j < nw && j < 64; j++) begin
      n_tests++;
      if (wr_addr[w0+j] !== ADDR_W'(16'h0100 + j) || wr_data[w0+j] !== DATA_W'(j % 32 + 1)) begin
        n_fail++; $display("FAIL pw_word%0d got a=%h d=%h want a=%h d=%h", j, wr_addr[w0+j],
                           wr_data[w0+j], 16'h0100 + j, j % 32 + 1);
      end
    end
    n_tests++;
    if (fetch_addr.size() - f0 != 2 || fetch_addr[f0] !== 16'h0100 || fetch_addr[f0+1] !== 16'h0120)
    begin
      n_fail++; $display("FAIL pw_fetch got n=%0d want 2 fetches 0100,0120", fetch_addr.size() - f0);
    end
    n_tests++; if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL pw_done_pulses got %0d want 1", done_cnt - d0);
    end
    n_tests++; if (done_cyc - sc != 68) begin
      n_fail++; $display("FAIL pw_latency got %0d want 68", done_cyc - sc);
    end
    n_tests++; if (busy_cnt - b0 != 68) begin
      n_fail++; $display("FAIL pw_busy_cycles got %0d want 68", busy_cnt - b0);
    end
    n_tests++; if (arr_cnt - a0 != 2) begin
      n_fail++; $display("FAIL pw_array_accepts got %0d want 2", arr_cnt - a0);
    end
    n_tests++; if (sif.DW_PW_sel !== 1'b1 || sif.ipsum2reducer !== ramp(16'hA000)) begin
      n_fail++; $display("FAIL pw_reducer_inputs got sel=%0b want sel=1 and ipsum ramp A000",
                         sif.DW_PW_sel);
    end
  endtask

  task automatic test_dw_pass();
    int sc, w0, f0, d0, p0, nw;
    bit to;
    sif.ipsum_vec = ramp(16'hB000); sif.reducer2opsum = ramp(16'h1000);
    w0 = wr_addr.size(); f0 = fetch_addr.size(); d0 = done_cnt; p0 = pw_cnt;
    do_start(1'b0, 16'd1, 16'h0200, sc);
    wait_done(d0, 100, to);
    repeat (3) tick();
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL dw_timeout got timeout want done"); end
    nw = wr_addr.size() - w0;
    n_tests++; if (nw != 10) begin n_fail++; $display("FAIL dw_count got %0d want 10", nw); end
    for (int j = 0; j < nw && j < 10; j++) begin
      n_tests++;
      if (wr_addr[w0+j] !== ADDR_W'(16'h0200 + j) || wr_data[w0+j] !== DATA_W'(16'h1000 + 3*j)) begin
        n_fail++; $display("FAIL dw_word%0d got a=%h d=%h want a=%h d=%h", j, wr_addr[w0+j],
                           wr_data[w0+j], 16'h0200 + j, 16'h1000 + 3*j);
      end
    end
    n_tests++; if (fetch_addr.size() - f0 != 1 || fetch_addr[f0] !== 16'h0200) begin
      n_fail++; $display("FAIL dw_fetch got n=%0d want one fetch at 0200", fetch_addr.size() - f0);
    end
    n_tests++; if (pw_cnt - p0 != 0 || sif.DW_PW_sel !== 1'b0) begin
      n_fail++; $display("FAIL dw_sel got %0d PW cycles want 0", pw_cnt - p0);
    end
    n_tests++; if (done_cyc - sc != 12) begin
      n_fail++; $display("FAIL dw_latency got %0d want 12", done_cyc - sc);
    end
  endtask

  task automatic test_backpressure();
    int sc, w0, d0, s0, v0, st0, nw, i;
    bit to;
    sif.reducer2opsum = ramp(16'h0500);
    sif.opsum_ready = 1'b0;
    w0 = wr_addr.size(); d0 = done_cnt; s0 = stall_viol; st0 = stall_cnt; v0 = valid_cnt;
    do_start(1'b1, 16'd1, 16'h0300, sc);
    to = 1'b1;
    i = 0;
    while (i < 400) begin
      sif.opsum_ready = ((i % 2) == 0) && !(i >= 15 && i < 20);
      tick();
      i++;
      if (done_cnt > d0) begin
        to = 1'b0;
        break;
      end
    end
    sif.opsum_ready = 1'b1;
    repeat (2) tick();
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got timeout want done"); end
    nw = wr_addr.size() - w0;
    n_tests++; if (nw != 32) begin n_fail++; $display("FAIL bp_count got %0d want 32", nw); end
    for (int j = 0; j < nw && j < 32; j++) begin
      n_tests++;
      if (wr_addr[w0+j] !== ADDR_W'(16'h0300 + j) || wr_data[w0+j] !== DATA_W'(16'h0500 + j)) begin
        n_fail++; $display("FAIL bp_word%0d got a=%h d=%h want a=%h d=%h", j, wr_addr[w0+j],
                           wr_data[w0+j], 16'h0300 + j, 16'h0500 + j);
      end
    end
    n_tests++; if (stall_viol - s0 != 0) begin
      n_fail++; $display("FAIL bp_stall_hold got %0d changes want 0", stall_viol - s0);
    end
    n_tests++; if (stall_cnt - st0 < 5) begin
      n_fail++; $display("FAIL bp_stall_seen got %0d stall cycles want >=5", stall_cnt - st0);
    end
    n_tests++; if (valid_cnt - v0 != 32 + (stall_cnt - st0)) begin
      n_fail++; $display("FAIL bp_valid_cycles got %0d want %0d", valid_cnt - v0,
                         32 + (stall_cnt - st0));
    end
  endtask

  task automatic test_zero_tiles();
    int sc, d0, r0, a0, v0;
    bit to;
    d0 = done_cnt; r0 = req_cnt; a0 = arr_cnt; v0 = valid_cnt;
    do_start(1'b1, 16'd0, 16'h0900, sc);
    wait_done(d0, 10, to);
    repeat (3) tick();
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL zero_timeout got timeout want done"); end
    n_tests++; if (done_cyc - sc != 0 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL zero_done got offset=%0d pulses=%0d want 0/1", done_cyc - sc,
                         done_cnt - d0);
    end
    n_tests++; if (req_cnt != r0 || arr_cnt != a0 || valid_cnt != v0) begin
      n_fail++; $display("FAIL zero_activity got req=%0d arr=%0d val=%0d want 0/0/0",
                         req_cnt - r0, arr_cnt - a0, valid_cnt - v0);
    end
  endtask

  task automatic test_ignored_start();
    int sc, w0, f0, d0, nw;
    sif.reducer2opsum = ramp(16'h0040);
    w0 = wr_addr.size(); f0 = fetch_addr.size(); d0 = done_cnt;
    do_start(1'b1, 16'd1, 16'h0400, sc);
    repeat (10) tick();
    start = 1'b1; mode = 1'b0; num_tiles = 16'd3; base_addr = 16'h0800;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cyc >= sc + 34) break;
      tick();
    end
    // FIN cycle: this start must be dropped as well
    start = 1'b1; mode = 1'b1; num_tiles = 16'd1; base_addr = 16'h0A00;
    tick();
    start = 1'b0;
    repeat (6) tick();
    nw = wr_addr.size() - w0;
    n_tests++; if (nw != 32) begin n_fail++; $display("FAIL ign_count got %0d want 32", nw); end
    for (int j = 0; j < nw && j < 32; j++) begin
      n_tests++;
      if (wr_addr[w0+j] !== ADDR_W'(16'h0400 + j) || wr_data[w0+j] !== DATA_W'(16'h0040 + j)) begin
        n_fail++; $display("FAIL ign_word%0d got a=%h d=%h want a=%h d=%h", j, wr_addr[w0+j],
                           wr_data[w0+j], 16'h0400 + j, 16'h0040 + j);
      end
    end
    n_tests++; if (fetch_addr.size() - f0 != 1) begin
      n_fail++; $display("FAIL ign_fetches got %0d want 1", fetch_addr.size() - f0);
    end
    n_tests++; if (done_cnt - d0 != 1 || done_cyc - sc != 34) begin
      n_fail++; $display("FAIL ign_done got pulses=%0d offset=%0d want 1/34", done_cnt - d0,
                         done_cyc - sc);
    end
    n_tests++; if (busy !== 1'b0 || sif.DW_PW_sel !== 1'b1) begin
      n_fail++; $display("FAIL ign_final got busy=%0b sel=%0b want 0/1", busy, sif.DW_PW_sel);
    end
  endtask

  task automatic test_reset_mid();
    int sc, w0, d0, r0, nw;
    bit to;
    sif.reducer2opsum = ramp(16'h0050);
    w0 = wr_addr.size();
    do_start(1'b1, 16'd1, 16'h0500, sc);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wr_addr.size() - w0 >= 5) break;
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (sif.opsum_valid !== 1'b1 || sif.opsum_addr !== 16'h0505) begin
      n_fail++; $display("FAIL rstmid_word5 got v=%0b a=%h want 1/0505", sif.opsum_valid,
                         sif.opsum_addr);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sif.ipsum_req !== 1'b0 || sif.array_ready !== 1'b0 ||
        sif.opsum_valid !== 1'b0 || sif.opsum_addr !== '0 || sif.opsum_data !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs got busy=%0b done=%0b req=%0b rdy=%0b v=%0b a=%h d=%h want all 0",
                         busy, done, sif.ipsum_req, sif.array_ready, sif.opsum_valid,
                         sif.opsum_addr, sif.opsum_data);
    end
    n_tests++; if (sif.ipsum2reducer !== '0 || sif.DW_PW_sel !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_regs got sel=%0b want ipsum2reducer 0 and sel 0", sif.DW_PW_sel);
    end
    d0 = done_cnt; r0 = req_cnt;
    repeat (40) tick();
    n_tests++; if (done_cnt != d0 || req_cnt != r0) begin
      n_fail++; $display("FAIL rstmid_quiet got done=%0d req=%0d want 0/0", done_cnt - d0,
                         req_cnt - r0);
    end
    sif.reducer2opsum = ramp(16'h2000);
    w0 = wr_addr.size(); d0 = done_cnt;
    do_start(1'b0, 16'd1, 16'h0600, sc);
    wait_done(d0, 100, to);
    repeat (2) tick();
    nw = wr_addr.size() - w0;
    n_tests++; if (to !== 1'b0 || nw != 10) begin
      n_fail++; $display("FAIL rstmid_restart got timeout=%0b count=%0d want 0/10", to, nw);
    end
    for (int j = 0; j < nw && j < 10; j++) begin
      n_tests++;
      if (wr_addr[w0+j] !== ADDR_W'(16'h0600 + j) || wr_data[w0+j] !== DATA_W'(16'h2000 + 3*j)) begin
        n_fail++; $display("FAIL rstmid_word%0d got a=%h d=%h want a=%h d=%h", j, wr_addr[w0+j],
                           wr_data[w0+j], 16'h0600 + j, 16'h2000 + 3*j);
      end
    end
  endtask

  task automatic test_relu();
    int sc, w0, d0, nw;
    bit to;
    logic [VEC_W-1:0] v;
    logic [DATA_W-1:0] exp0;
`ifdef REDUCER_SEQ_RELU_EN
    exp0 = 16'h0000;
`else
    exp0 = 16'h8001;
`endif
    v = ramp(16'h0000);
    v[0 +: DATA_W] = 16'h8001;
    v[DATA_W +: DATA_W] = 16'h7FFF;
    sif.reducer2opsum = v;
    w0 = wr_addr.size(); d0 = done_cnt;
    do_start(1'b1, 16'd1, 16'h0700, sc);
    wait_done(d0, 100, to);
    repeat (2) tick();
    nw = wr_addr.size() - w0;
    n_tests++; if (to !== 1'b0 || nw != 32) begin
      n_fail++; $display("FAIL relu_count got timeout=%0b count=%0d want 0/32", to, nw);
    end
    n_tests++; if (nw > 1 && (wr_data[w0] !== exp0 || wr_data[w0+1] !== 16'h7FFF)) begin
      n_fail++; $display("FAIL relu_data got %h,%h want %h,7fff", wr_data[w0], wr_data[w0+1], exp0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pw_pass();
    test_dw_pass();
    test_backpressure();
    test_zero_tiles();
    test_ignored_start();
    test_reset_mid();
    test_relu();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
